irq_capture_4: RTL and testbench

Four-channel request capture stage feeding the team's 4-to-2 priority encoder. It does four things:
- synchronises four asynchronous request lines;
- detects rising edges and holds them as sticky pending bits;
- applies a per-channel enable mask and presents the result as a 4-bit vector for the encoder;
- clears a pending bit when the downstream service acknowledges the encoded index.

Lost (re-asserted while pending) requests are flagged in sticky overflow bits.

---
 rtl/irq_pkg.sv | 15 +
 rtl/sync_chain.sv | 21 ++
 rtl/irq_capture_4.sv | 72 +++++++
 tb/tb_irq_capture_4.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the four-channel request capture stage.
package irq_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;

  // One-hot clear vector for an acknowledged encoder index.
  function automatic req_vec_t ack_decode(input req_idx_t idx);
    ack_decode = req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-bit, multi-stage flop synchroniser with asynchronous active-low reset.
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg <= '0;
    else        stg <= {stg[STAGES-2:0], d};
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/irq_capture_4.sv
// Four-channel request capture: synchronise, edge-detect, hold pending,
// mask for the priority encoder, and flag requests lost while pending.
module irq_capture_4
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE        = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req_async,
  input  req_vec_t mask,
  output req_vec_t pend,
  output logic     irq,
  input  logic     ack,
  input  req_idx_t ack_idx,
  output req_vec_t ovf,
  input  logic     ovf_clr
);

  req_vec_t s;
  req_vec_t prev;
  req_vec_t rise;
  req_vec_t raw_pend;
  req_vec_t raw_next;
  req_vec_t ovf_next;
  req_vec_t clr_vec;

  sync_chain #(
    .WIDTH  (N_REQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_async),
    .q     (s)
  );

  assign rise = s & ~prev;

  // Set beats clear on the same channel; a rise that coincides with its
  // own ack is a fresh capture, not a lost request.
  always_comb begin
    clr_vec  = '0;
    raw_next = '0;
    ovf_next = '0;
    if (ack) clr_vec = ack_decode(ack_idx);
    if (EDGE != 0) begin
      raw_next = rise | (raw_pend & ~clr_vec);
      ovf_next = (rise & raw_pend & ~clr_vec) | (ovf_clr ? '0 : ovf);
    end else begin
      raw_next = s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      raw_pend <= '0;
      ovf      <= '0;
    end else begin
      prev     <= s;
      raw_pend <= raw_next;
      ovf      <= ovf_next;
    end
  end

  // Mask only gates visibility; held state survives masking.
  assign pend = raw_pend & mask;
  assign irq  = |pend;

endmodule

// File: tb/tb_irq_capture_4.sv
// Directed self-checking bench for irq_capture_4 in edge and level builds.
module tb_irq_capture_4;
  import irq_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  req_vec_t req_async;
  req_vec_t mask;
  logic     ack;
  req_idx_t ack_idx;
  logic     ovf_clr;

  req_vec_t pend,     ovf;
  logic     irq;
  req_vec_t pend_lvl, ovf_lvl;
  logic     irq_lvl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_capture_4 #(.SYNC_STAGES(2), .EDGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_async(req_async), .mask(mask),
    .pend(pend), .irq(irq), .ack(ack), .ack_idx(ack_idx),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  irq_capture_4 #(.SYNC_STAGES(2), .EDGE(0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .req_async(req_async), .mask(mask),
    .pend(pend_lvl), .irq(irq_lvl), .ack(ack), .ack_idx(ack_idx),
    .ovf(ovf_lvl), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input req_idx_t idx);
    ack = 1'b1;
    ack_idx = idx;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_async = '0; mask = 4'hF;
    ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
    tick(2);
    check("rst_pend", 8'(pend), 8'h0);
    check("rst_irq",  8'(irq),  8'h0);
    check("rst_ovf",  8'(ovf),  8'h0);
    rst_n = 1'b1;
    tick(2);

    // Single capture: visible exactly three edges after first sampling.
    req_async = 4'b0100;
    tick(2);
    check("lat_early_pend", 8'(pend), 8'h0);
    check("lat_early_irq",  8'(irq),  8'h0);
    tick();
    check("lat_pend", 8'(pend), 8'b0100);
    check("lat_irq",  8'(irq),  8'h1);
    check("lvl_pend", 8'(pend_lvl), 8'b0100);
    do_ack(2'd2);
    check("ack2_pend", 8'(pend), 8'h0);
    check("ack2_irq",  8'(irq),  8'h0);
    check("lvl_ack_ignored", 8'(pend_lvl), 8'b0100);
    req_async = '0;
    tick(3);
    check("lvl_fall", 8'(pend_lvl), 8'h0);
    check("lvl_ovf",  8'(ovf_lvl),  8'h0);

    // Two channels, back-to-back acks.
    req_async = 4'b1001;
    tick(3);
    check("two_pend", 8'(pend), 8'b1001);
    do_ack(2'd3);
    check("b2b_ack3", 8'(pend), 8'b0001);
    do_ack(2'd0);
    check("b2b_ack0", 8'(pend), 8'b0000);
    req_async = '0;
    tick(3);

    // Masked capture is held and exposed combinationally on unmask.
    mask = 4'b1110;
    req_async = 4'b0001;
    tick(2);
    req_async = '0;
    tick(3);
    check("masked_pend", 8'(pend), 8'h0);
    check("masked_irq",  8'(irq),  8'h0);
    mask = 4'hF;
    #1;
    check("unmask_pend", 8'(pend), 8'b0001);
    check("unmask_irq",  8'(irq),  8'h1);
    do_ack(2'd0);
    check("unmask_ack", 8'(pend), 8'h0);

    // Duplicate rise while pending flags overflow.
    req_async = 4'b0010;
    tick(3);
    check("ch1_pend", 8'(pend), 8'b0010);
    req_async = '0;
    tick(3);
    req_async = 4'b0010;
    tick(3);
    check("ovf_set",  8'(ovf),  8'b0010);
    check("ovf_pend", 8'(pend), 8'b0010);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 8'(ovf), 8'h0);
    do_ack(2'd1);
    check("ch1_ack", 8'(pend), 8'h0);
    req_async = '0;
    tick(3);

    // Rise and ack of the same channel in the same cycle: set wins.
    req_async = 4'b0010;
    tick(3);
    req_async = '0;
    tick(3);
    req_async = 4'b0010;
    tick(2);
    do_ack(2'd1);
    check("setwins_pend", 8'(pend), 8'b0010);
    check("setwins_ovf",  8'(ovf),  8'h0);
    do_ack(2'd1);
    check("setwins_clr", 8'(pend), 8'h0);
    req_async = '0;
    tick(3);

    // Async reset mid-operation with pending and overflow state.
    req_async = 4'b0100;
    tick(3);
    req_async = '0;
    tick(3);
    req_async = 4'b0100;
    tick(3);
    check("pre_rst_ovf",  8'(ovf),  8'b0100);
    check("pre_rst_pend", 8'(pend), 8'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pend", 8'(pend), 8'h0);
    check("async_rst_irq",  8'(irq),  8'h0);
    check("async_rst_ovf",  8'(ovf),  8'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_early", 8'(pend), 8'h0);
    tick();
    check("post_rst_cap", 8'(pend), 8'b0100);
    check("post_rst_lvl", 8'(pend_lvl), 8'b0100);
    do_ack(2'd2);
    tick(3);
    check("post_rst_once", 8'(pend), 8'h0);
    check("post_rst_ovf",  8'(ovf),  8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
